// File: rtl/regfile_param.sv
// Parametrised register file with a one-entry-per-cycle clear sequencer, optional x0
// hardwiring, same-cycle write forwarding and a fixed debug tap.
module regfile_rd_port #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            busy,
    input  logic [AW-1:0]   rd_idx,
    input  logic [XLEN-1:0] arr_data,
    input  logic            wr_acc,
    input  logic [AW-1:0]   wr_idx,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] rd_data
);
    always_comb begin
        rd_data = arr_data;
        if (busy)
            rd_data = '0;
        else if ((ZERO_REG != 0) && (rd_idx == '0))
            rd_data = '0;
        else if ((BYPASS != 0) && wr_acc && (wr_idx == rd_idx))
            rd_data = wr_data;
    end
endmodule

module regfile_param #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int TAP_IDX  = 10,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_idx,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                clr_req,
    input  logic [NRD*AW-1:0]   rd_idx,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [XLEN-1:0]     tap_data,
    output logic                busy,
    output logic                wr_drop,
    output logic [7:0]          drop_cnt
);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
    localparam logic [AW-1:0] TAP  = AW'(TAP_IDX);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t          state;
    logic [AW-1:0]   clr_ptr;
    logic [XLEN-1:0] regs [NREGS];
    logic            wr_acc;
    logic            drop;

    // Clear wins over a colliding write; x0 writes are silently ignored, not dropped.
    assign drop   = wr_en & (busy | clr_req);
    assign wr_acc = wr_en & ~busy & ~clr_req & ~((ZERO_REG != 0) && (wr_idx == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: if (clr_req) begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                    busy    <= 1'b1;
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_drop  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            wr_drop <= drop;
            if (drop && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // No reset on the array so it can map to distributed RAM; the sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (busy)
            regs[clr_ptr] <= '0;
        else if (wr_acc)
            regs[wr_idx] <= wr_data;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] idx;
        assign idx = rd_idx[k*AW +: AW];
        regfile_rd_port #(
            .XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_rd (
            .busy    (busy),
            .rd_idx  (idx),
            .arr_data(regs[idx]),
            .wr_acc  (wr_acc),
            .wr_idx  (wr_idx),
            .wr_data (wr_data),
            .rd_data (rd_data[k*XLEN +: XLEN])
        );
    end

    assign tap_data = (busy || ((ZERO_REG != 0) && (TAP == '0))) ? '0 : regs[TAP];
endmodule
